// File: rtl/kn_tile_reader.sv
// kn_tile_reader: read-side initiator for the k/n attention-score SRAM.
// Walks rows k_base..k_base+k_len-1 (all N columns per row, n fastest),
// issues credit-limited SRAM reads, buffers responses in a small FIFO and
// drains them onto a valid/ready stream tagged with k, n and last flags.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, k_base, k_len            tile launch and geometry (sampled on accepted start)
//   busy, done, err_ovf             status: running, completion pulse, sticky overflow
//   x_en, x_re, x_we, x_k, x_n      SRAM request (read only, write side tied off)
//   x_wdata, x_wmask                SRAM write data/mask, constant 0
//   x_rdata, x_rvalid               SRAM in-order read response
//   m_valid, m_ready, m_data        output stream
//   m_k, m_n, m_last_n, m_last      output stream tags
module kn_tile_reader #(
    parameter int unsigned KMAX       = 1024,
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned BYTE_W    = DATA_W / 8,
    localparam int unsigned K_W       = (KMAX <= 1) ? 1 : $clog2(KMAX),
    localparam int unsigned N_W       = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    k_base,
    input  logic [K_W:0]      k_len,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              x_en,
    output logic              x_re,
    output logic              x_we,
    output logic [K_W-1:0]    x_k,
    output logic [N_W-1:0]    x_n,
    output logic [DATA_W-1:0] x_wdata,
    output logic [BYTE_W-1:0] x_wmask,
    input  logic [DATA_W-1:0] x_rdata,
    input  logic              x_rvalid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [K_W-1:0]    m_k,
    output logic [N_W-1:0]    m_n,
    output logic              m_last_n,
    output logic              m_last
);

    localparam int unsigned T_W = K_W + N_W + 1;
    localparam int unsigned A_W = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned C_W = A_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              start_c, issue_c;

    logic [K_W-1:0]    k_base_q;
    logic [T_W-1:0]    total_q;
    logic [K_W-1:0]    row_q;
    logic [N_W-1:0]    col_q;
    logic [T_W-1:0]    iss_cnt_q;
    logic              x_en_q;
    logic [K_W-1:0]    x_k_q;
    logic [N_W-1:0]    x_n_q;

    logic [K_W-1:0]    out_row_q;
    logic [N_W-1:0]    out_col_q;
    logic [T_W-1:0]    out_cnt_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [A_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [C_W-1:0]    cnt_q, infl_q;
    logic              err_q;

    logic              fifo_full_c, fifo_nempty_c, pop_c, rsp_c, push_c, ovf_c;
    logic              credit_c, last_issue_c, last_pop_c;

    // Credit: every outstanding read must already own a FIFO slot
    assign credit_c      = (C_W'(cnt_q) + C_W'(infl_q)) < C_W'(FIFO_DEPTH) &&
                           ((C_W + 1)'(cnt_q) + (C_W + 1)'(infl_q)) < (C_W + 1)'(FIFO_DEPTH);
    assign last_issue_c  = (iss_cnt_q == total_q - T_W'(1));
    assign last_pop_c    = (out_cnt_q == total_q - T_W'(1));

    assign fifo_full_c   = (cnt_q == C_W'(FIFO_DEPTH));
    assign fifo_nempty_c = (cnt_q != '0);
    assign pop_c         = fifo_nempty_c && m_ready;
    // Responses with nothing outstanding are stale (e.g. from before a reset)
    assign rsp_c         = x_rvalid && (infl_q != '0);
    assign push_c        = rsp_c && (!fifo_full_c || pop_c);
    assign ovf_c         = rsp_c && fifo_full_c && !pop_c;

    // FSM next-state and registered-output next values
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = (state_q == DONE);
        start_c = 1'b0;
        issue_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_c = 1'b1;
                    busy_d  = 1'b1;
                    state_d = (k_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy_d  = 1'b1;
                issue_c = credit_c;
                if (credit_c && last_issue_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (pop_c && last_pop_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Tile geometry and read-address walker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_base_q  <= '0;
            total_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            iss_cnt_q <= '0;
            x_en_q    <= 1'b0;
            x_k_q     <= '0;
            x_n_q     <= '0;
        end else begin
            x_en_q <= issue_c;
            if (start_c) begin
                k_base_q  <= k_base;
                total_q   <= T_W'(k_len) * T_W'(N);
                row_q     <= '0;
                col_q     <= '0;
                iss_cnt_q <= '0;
            end else if (issue_c) begin
                x_k_q     <= k_base_q + row_q;
                x_n_q     <= col_q;
                iss_cnt_q <= iss_cnt_q + T_W'(1);
                if (col_q == N_W'(N - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + K_W'(1);
                end else begin
                    col_q <= col_q + N_W'(1);
                end
            end
        end
    end

    // Output-side tag counter, advanced once per popped word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q <= '0;
            out_col_q <= '0;
            out_cnt_q <= '0;
        end else if (start_c) begin
            out_row_q <= '0;
            out_col_q <= '0;
            out_cnt_q <= '0;
        end else if (pop_c) begin
            out_cnt_q <= out_cnt_q + T_W'(1);
            if (out_col_q == N_W'(N - 1)) begin
                out_col_q <= '0;
                out_row_q <= out_row_q + K_W'(1);
            end else begin
                out_col_q <= out_col_q + N_W'(1);
            end
        end
    end

    // Response FIFO pointers, occupancy, outstanding reads and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + A_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + A_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   cnt_q <= cnt_q + C_W'(1);
                2'b01:   cnt_q <= cnt_q - C_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            case ({issue_c, rsp_c})
                2'b10:   infl_q <= infl_q + C_W'(1);
                2'b01:   infl_q <= infl_q - C_W'(1);
                default: infl_q <= infl_q;
            endcase
            if (ovf_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= x_rdata;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_ovf  = err_q;
    assign x_en     = x_en_q;
    assign x_re     = x_en_q;
    assign x_we     = 1'b0;
    assign x_k      = x_k_q;
    assign x_n      = x_n_q;
    assign x_wdata  = '0;
    assign x_wmask  = '0;

    assign m_valid  = fifo_nempty_c;
    assign m_data   = fifo_nempty_c ? fifo_mem[rd_ptr_q] : '0;
    assign m_k      = fifo_nempty_c ? (k_base_q + out_row_q) : '0;
    assign m_n      = fifo_nempty_c ? out_col_q : '0;
    assign m_last_n = fifo_nempty_c && (out_col_q == N_W'(N - 1));
    assign m_last   = fifo_nempty_c && last_pop_c;

endmodule

// File: tb/tb_kn_tile_reader.sv
// tb_kn_tile_reader: table-driven and randomized checks of kn_tile_reader
// against a behavioural SRAM with configurable in-order latency and an
// arithmetic model of the expected stream and read-address sequence.
module tb_kn_tile_reader;

    localparam int KMAX  = 1024;
    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int K_W   = 10;
    localparam int N_W   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [K_W-1:0]  k_base = '0;
    logic [K_W:0]    k_len = '0;
    logic            busy, done, err_ovf;
    logic            x_en, x_re, x_we;
    logic [K_W-1:0]  x_k;
    logic [N_W-1:0]  x_n;
    logic [DW-1:0]   x_wdata;
    logic [DW/8-1:0] x_wmask;
    logic [DW-1:0]   x_rdata = '0;
    logic            x_rvalid = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic [K_W-1:0]  m_k;
    logic [N_W-1:0]  m_n;
    logic            m_last_n, m_last;

    kn_tile_reader #(.KMAX(KMAX), .N(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_base(k_base), .k_len(k_len),
        .busy(busy), .done(done), .err_ovf(err_ovf),
        .x_en(x_en), .x_re(x_re), .x_we(x_we), .x_k(x_k), .x_n(x_n),
        .x_wdata(x_wdata), .x_wmask(x_wmask), .x_rdata(x_rdata), .x_rvalid(x_rvalid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_k(m_k), .m_n(m_n),
        .m_last_n(m_last_n), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kb; int kl; int lat; int rdy; int hold; int glitch;
        int exp_words; int exp_first_k; int exp_last_k; int exp_span; int exp_busy; int exp_hold_iss;
    } vec_t;

    typedef struct { int due; logic [DW-1:0] data; } rsp_t;

    logic [DW-1:0] mem [KMAX*N];
    rsp_t          pend[$];
    logic [12:0]   issued[$];
    logic [46:0]   got[$];
    int            cyc = 0, last_due = -1, lat = 1, rdy_pct = 100;
    int            done_cnt, busy_cnt, done_cyc, first_pop, last_pop, we_bad = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: behavioural SRAM, random back-pressure, stream capture
    task automatic tick();
        int d;
        if (x_en && x_re) begin
            issued.push_back({x_k, x_n});
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{d, mem[int'(x_k) * N + int'(x_n)]});
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            x_rvalid = 1'b1;
            x_rdata  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            x_rvalid = 1'b0;
            x_rdata  = $urandom;
        end
        m_ready = ($urandom_range(99) < rdy_pct);
        if (x_we || x_wdata != '0 || x_wmask != '0) we_bad++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (m_valid && m_ready) begin
            got.push_back({m_data, m_k, m_n, m_last_n, m_last});
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [46:0] exp_word(input int kb, input int kl, input int j);
        int k, n;
        k = (kb + j / N) % KMAX;
        n = j % N;
        return {mem[k * N + n], K_W'(k), N_W'(n), 1'(n == N - 1), 1'(j == kl * N - 1)};
    endfunction

    task automatic run_tile(input vec_t v, input string tag);
        int start_cyc, ref_cyc;
        logic [12:0] e;
        issued.delete(); got.delete();
        done_cnt = 0; busy_cnt = 0; done_cyc = -1; first_pop = -1; last_pop = -1;
        lat = v.lat;
        rdy_pct = (v.hold > 0) ? 0 : v.rdy;
        k_base = K_W'(v.kb);
        k_len = (K_W + 1)'(v.kl);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0; k_base = '0; k_len = '0;
        if (v.hold > 0) begin
            for (int i = 1; i < v.hold; i++) tick();
            check({tag, "_hold_issued"}, 64'(issued.size()), 64'(v.exp_hold_iss));
            check({tag, "_hold_x_en"}, 64'(x_en), 64'(0));
            rdy_pct = v.rdy;
        end
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            if (v.glitch != 0 && i == 5 && busy) begin
                start = 1'b1; k_base = K_W'(7); k_len = (K_W + 1)'(3);
            end
            tick();
            start = 1'b0; k_base = '0; k_len = '0;
        end
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({tag, "_words"}, 64'(got.size()), 64'(v.exp_words));
        check({tag, "_reads"}, 64'(issued.size()), 64'(v.exp_words));
        for (int j = 0; j < got.size() && j < v.exp_words; j++)
            check($sformatf("%s_word%0d", tag, j), 64'(got[j]), 64'(exp_word(v.kb, v.kl, j)));
        for (int j = 0; j < issued.size() && j < v.exp_words; j++)
            check($sformatf("%s_addr%0d", tag, j), 64'(issued[j]),
                  64'({K_W'((v.kb + j / N) % KMAX), N_W'(j % N)}));
        ref_cyc = (v.exp_words > 0) ? last_pop : start_cyc;
        check({tag, "_done_lag"}, 64'(done_cyc - ref_cyc), 64'(2));
        check({tag, "_busy_window"}, 64'(busy_cnt), 64'(done_cyc - start_cyc - 1));
        if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
        if (v.exp_first_k >= 0 && issued.size() > 0) begin
            e = issued[0];
            check({tag, "_first_k"}, 64'(e[12:3]), 64'(v.exp_first_k));
            e = issued[issued.size() - 1];
            check({tag, "_last_k"}, 64'(e[12:3]), 64'(v.exp_last_k));
        end
        if (v.exp_span >= 0) check({tag, "_span"}, 64'(last_pop - first_pop), 64'(v.exp_span));
        check({tag, "_err_ovf"}, 64'(err_ovf), 64'(0));
        check({tag, "_wr_tieoff"}, 64'(we_bad), 64'(0));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   n_pre;
        for (int i = 0; i < KMAX * N; i++) mem[i] = $urandom;
        //             kb    kl lat rdy hold gl words first last span busy hiss
        vecs[0] = '{   0,   2,  1, 100,  0, 0,  16,    0,   1,  15,  20,  -1};
        vecs[1] = '{   5,   0,  1, 100,  0, 0,   0,   -1,  -1,  -1,   1,  -1};
        vecs[2] = '{1023,   2,  1, 100,  0, 0,  16, 1023,   0,  15,  20,  -1};
        vecs[3] = '{  10,   2,  1, 100, 20, 0,  16,   10,  11,  -1,  -1,   4};
        vecs[4] = '{ 100,   3,  3,  60,  0, 1,  24,  100, 102,  -1,  -1,  -1};
        vecs[5] = '{ 512,   1,  2, 100,  0, 0,   8,  512, 512,  -1,  -1,  -1};

        // Reset state
        tick(); tick();
        check("reset_outputs",
              64'({busy, done, err_ovf, x_en, x_re, x_we, x_k, x_n, m_valid, m_k, m_n, m_last_n, m_last}),
              64'(0));
        check("reset_m_data", 64'(m_data), 64'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-ISSUE with two reads outstanding
        issued.delete(); got.delete();
        lat = 3; rdy_pct = 0;
        k_base = K_W'(20); k_len = (K_W + 1)'(2); start = 1'b1;
        tick();
        start = 1'b0; k_base = '0; k_len = '0;
        for (int i = 0; i < 20 && issued.size() < 2; i++) tick();
        check("rst_pre_issued", 64'(issued.size()), 64'(2));
        rst_n = 1'b0;
        #1;
        check("rst_async_clear",
              64'({busy, done, err_ovf, x_en, x_re, x_k, x_n, m_valid, m_last_n, m_last}), 64'(0));
        n_pre = issued.size();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("rst_pend_flushed", 64'(pend.size()), 64'(0));
        check("rst_no_new_reads", 64'(issued.size()), 64'(n_pre));
        check("rst_stale_dropped", 64'(m_valid), 64'(0));
        check("rst_err_ovf", 64'(err_ovf), 64'(0));
        check("rst_idle", 64'({busy, done}), 64'(0));
        run_tile(vecs[0], "post_rst");

        // Randomized tiles, SRAM latency 3, random back-pressure
        for (int t = 0; t < 6; t++) begin
            rv.kb = $urandom_range(KMAX - 1);
            rv.kl = $urandom_range(4, 1);
            rv.lat = 3; rv.rdy = 50; rv.hold = 0; rv.glitch = $urandom_range(1);
            rv.exp_words = rv.kl * N;
            rv.exp_first_k = rv.kb;
            rv.exp_last_k = (rv.kb + rv.kl - 1) % KMAX;
            rv.exp_span = -1; rv.exp_busy = -1; rv.exp_hold_iss = -1;
            run_tile(rv, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
